// File: rtl/speed_tick_gen.sv
// Single-clock speed-level generator: a prescaler emits a one-cycle tick every PRESCALE
// enabled cycles, and each tick advances a WIDTH-bit speed level by the selected mode.
module speed_tick_gen #(
   parameter int unsigned PRESCALE = 100,
   parameter int unsigned WIDTH    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] speed,
   output logic             tick,
   output logic             at_max,
   output logic             at_min
);

   localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] MaxVal = '1;
   localparam logic [WIDTH-1:0] MinVal = '0;
   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   typedef enum logic [1:0] {
      ModeWrapUp   = 2'b00,
      ModeWrapDown = 2'b01,
      ModeSatUp    = 2'b10,
      ModePingPong = 2'b11
   } mode_e;

   typedef enum logic {
      DirUp   = 1'b0,
      DirDown = 1'b1
   } dir_e;

   logic [PreW-1:0]  pre_q, pre_d;
   logic [WIDTH-1:0] speed_q, speed_d;
   logic             tick_q, tick_d;
   dir_e             dir_q, dir_d;
   logic             wrap;

   assign wrap = enable && !load && (pre_q == PreLast);

   always_comb begin
      pre_d   = pre_q;
      speed_d = speed_q;
      tick_d  = 1'b0;
      dir_d   = dir_q;
      if (load) begin
         // Load restarts the tick period and drops any coincident wrap.
         speed_d = load_value;
         pre_d   = '0;
         dir_d   = DirUp;
      end else if (enable) begin
         if (wrap) begin
            pre_d  = '0;
            tick_d = 1'b1;
            unique case (mode_e'(mode))
               ModeWrapUp:   speed_d = speed_q + One;
               ModeWrapDown: speed_d = speed_q - One;
               ModeSatUp:    speed_d = (speed_q == MaxVal) ? MaxVal : speed_q + One;
               ModePingPong: begin
                  if (dir_q == DirUp) begin
                     if (speed_q == MaxVal) begin
                        speed_d = MaxVal - One;
                        dir_d   = DirDown;
                     end else begin
                        speed_d = speed_q + One;
                     end
                  end else begin
                     if (speed_q == MinVal) begin
                        speed_d = One;
                        dir_d   = DirUp;
                     end else begin
                        speed_d = speed_q - One;
                     end
                  end
               end
               default: speed_d = speed_q;
            endcase
         end else begin
            pre_d = pre_q + PreW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q   <= '0;
         speed_q <= '0;
         tick_q  <= 1'b0;
         dir_q   <= DirUp;
      end else begin
         pre_q   <= pre_d;
         speed_q <= speed_d;
         tick_q  <= tick_d;
         dir_q   <= dir_d;
      end
   end

   assign speed  = speed_q;
   assign tick   = tick_q;
   assign at_max = (speed_q == MaxVal);
   assign at_min = (speed_q == MinVal);

endmodule
